// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with req/ack data-memory port, upstream stall and MEM/WB register
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  wb_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  rd_o,
    output logic        err_o
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, alu_q, alu_d;
    logic [1:0] ctx_wb_q, ctx_wb_d, wb_q, wb_d;
    logic [4:0] ctx_rd_q, ctx_rd_d, rd_q, rd_d;
    logic idle, access, misaligned, issue, pass, done, expire;
    assign idle       = state_q == IDLE;
    assign access     = mem_read_i | mem_write_i;
    assign misaligned = access & (addr_i[1:0] != 2'b00);
    assign issue      = idle & access & ~misaligned;
    assign pass       = idle & ~access;
    assign done       = ~idle & dmem_ack_i;
    assign expire     = ~idle & ~dmem_ack_i & (TIMEOUT != 0) & (cnt_q == LAST);
    assign stall_o      = ~rst & (issue | (~idle & ~dmem_ack_i & ~expire));
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_o         = wb_q;
    assign rdata_o      = rdata_q;
    assign alu_o        = alu_q;
    assign rd_o         = rd_q;
    assign err_o        = err_q;
    // state and datapath registers, cleared asynchronously so a pending request drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ctx_wb_q <= 2'd0;
            ctx_rd_q <= 5'd0;
            wb_q     <= 2'd0;
            rd_q     <= 5'd0;
            alu_q    <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ctx_wb_q <= ctx_wb_d;
            ctx_rd_q <= ctx_rd_d;
            wb_q     <= wb_d;
            rd_q     <= rd_d;
            alu_q    <= alu_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
    // next state: enter WAIT on an aligned access, leave on ack or timeout
    always_comb begin
        state_d = issue ? WAIT : (done | expire) ? IDLE : state_q;
    end
    // request port, captured context and MEM/WB contents; anything not passed or completed is a bubble
    always_comb begin
        cnt_d    = issue ? '0 : idle ? cnt_q : cnt_q + 1'b1;
        req_d    = issue | (~idle & ~done & ~expire);
        we_d     = issue ? mem_write_i : we_q;
        addr_d   = issue ? addr_i : addr_q;
        wdata_d  = issue ? wdata_i : wdata_q;
        ctx_wb_d = issue ? wb_i : ctx_wb_q;
        ctx_rd_d = issue ? rd_i : ctx_rd_q;
        wb_d     = pass ? wb_i : done ? ctx_wb_q : 2'd0;
        rd_d     = pass ? rd_i : done ? ctx_rd_q : 5'd0;
        alu_d    = pass ? addr_i : done ? addr_q : 32'd0;
        rdata_d  = (done & ~we_q) ? dmem_rdata_i : 32'd0;
        err_d    = (idle & misaligned) | expire;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: vector table, directed corner sequences and randomized run against a behavioural model
module tb_mem_access_stage;
    localparam int TMO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] wb_i = '0;
    logic mem_read_i = 1'b0, mem_write_i = 1'b0, dmem_ack_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0, dmem_rdata_i = '0;
    logic [4:0] rd_i = '0;
    logic dmem_req_o, dmem_we_o, stall_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, rdata_o, alu_o;
    logic [1:0] wb_o;
    logic [4:0] rd_o;

    mem_access_stage #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .wb_i(wb_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .wb_o(wb_o), .rdata_o(rdata_o), .alu_o(alu_o),
        .rd_o(rd_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int stall_cnt, req_cnt;
    bit last_stall;

    // behavioural model: pending-access bookkeeping and expected registered outputs
    bit m_busy;
    int m_waited;
    logic [1:0] m_wb;
    logic [4:0] m_rd;
    logic e_req, e_we, e_err, e_chk_data;
    logic [31:0] e_addr, e_wdata, e_rdata, e_alu;
    logic [1:0] e_wb;
    logic [4:0] e_rd;

    typedef struct {
        logic [1:0] wb; logic rd_en; logic wr_en; logic [31:0] addr; logic [4:0] rd;
        logic [1:0] x_wb; logic [4:0] x_rd; logic [31:0] x_alu; logic x_err; bit chk_alu;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_wb = 0; m_rd = 0;
        e_req = 0; e_we = 0; e_err = 0; e_addr = 0; e_wdata = 0;
        e_rdata = 0; e_alu = 0; e_wb = 0; e_rd = 0; e_chk_data = 1;
    endtask

    function automatic bit exp_stall();
        bit acc = mem_read_i | mem_write_i;
        bit mis = acc && (addr_i[1:0] != 2'b00);
        if (!m_busy) return acc && !mis;
        return !dmem_ack_i && (m_waited + 1 != TMO);
    endfunction

    task automatic model_step();
        bit acc = mem_read_i | mem_write_i;
        bit mis = acc && (addr_i[1:0] != 2'b00);
        if (!m_busy) begin
            e_err = mis;
            e_chk_data = 0;
            if (!acc) begin
                e_wb = wb_i; e_rd = rd_i; e_alu = addr_i; e_rdata = 0; e_chk_data = 1;
            end else if (mis) begin
                e_wb = 0; e_rd = 0;
            end else begin
                m_busy = 1; m_waited = 0; e_req = 1; e_we = mem_write_i;
                e_addr = addr_i; e_wdata = wdata_i; m_wb = wb_i; m_rd = rd_i;
                e_wb = 0; e_rd = 0;
            end
        end else begin
            e_err = 0;
            e_chk_data = 0;
            if (dmem_ack_i) begin
                m_busy = 0; e_req = 0; e_wb = m_wb; e_rd = m_rd; e_alu = e_addr;
                e_rdata = e_we ? 32'd0 : dmem_rdata_i; e_chk_data = 1;
            end else if (m_waited + 1 == TMO) begin
                m_busy = 0; e_req = 0; e_err = 1; e_wb = 0; e_rd = 0;
            end else begin
                m_waited++; e_wb = 0; e_rd = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("stall", stall_o, exp_stall());
        chk("req", dmem_req_o, e_req);
        chk("err", err_o, e_err);
        chk("wb", wb_o, e_wb);
        chk("rd", rd_o, e_rd);
        if (e_req) begin
            chk("we", dmem_we_o, e_we);
            chk("addr", dmem_addr_o, e_addr);
            chk("wdata", dmem_wdata_o, e_wdata);
        end
        if (e_chk_data) begin
            chk("alu", alu_o, e_alu);
            chk("rdata", rdata_o, e_rdata);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        stall_cnt += int'(stall_o);
        req_cnt += int'(dmem_req_o);
        last_stall = exp_stall();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst.req", dmem_req_o, 0);
        chk("rst.we", dmem_we_o, 0);
        chk("rst.addr", dmem_addr_o, 0);
        chk("rst.wdata", dmem_wdata_o, 0);
        chk("rst.stall", stall_o, 0);
        chk("rst.wb", wb_o, 0);
        chk("rst.rdata", rdata_o, 0);
        chk("rst.alu", alu_o, 0);
        chk("rst.rd", rd_o, 0);
        chk("rst.err", err_o, 0);
        model_reset();
        last_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_op(input logic [1:0] wb, input logic rd_en, input logic wr_en,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        wb_i = wb; mem_read_i = rd_en; mem_write_i = wr_en; addr_i = addr; wdata_i = wdata; rd_i = rd;
    endtask

    initial begin
        tbl[0] = '{2'b10, 0, 0, 32'h0000_0040, 5'd5,  2'b10, 5'd5,  32'h0000_0040, 0, 1};
        tbl[1] = '{2'b01, 0, 0, 32'hFFFF_FFFF, 5'd31, 2'b01, 5'd31, 32'hFFFF_FFFF, 0, 1};
        tbl[2] = '{2'b11, 1, 0, 32'h0000_0102, 5'd9,  2'b00, 5'd0,  32'h0,         1, 0};
        tbl[3] = '{2'b11, 0, 1, 32'h0000_0103, 5'd9,  2'b00, 5'd0,  32'h0,         1, 0};
        tbl[4] = '{2'b10, 1, 1, 32'h0000_0001, 5'd2,  2'b00, 5'd0,  32'h0,         1, 0};
        tbl[5] = '{2'b00, 0, 0, 32'h1234_5678, 5'd0,  2'b00, 5'd0,  32'h1234_5678, 0, 1};
        @(posedge clk);
        #1;
        do_reset();

        // single-cycle IDLE behaviour: pass-through and misaligned bubbles
        for (int i = 0; i < 6; i++) begin
            set_op(tbl[i].wb, tbl[i].rd_en, tbl[i].wr_en, tbl[i].addr, 32'h0, tbl[i].rd);
            @(negedge clk);
            chk("tbl.stall", stall_o, 0);
            model_step();
            @(posedge clk);
            #1;
            chk("tbl.req", dmem_req_o, 0);
            chk("tbl.wb", wb_o, tbl[i].x_wb);
            chk("tbl.rd", rd_o, tbl[i].x_rd);
            chk("tbl.err", err_o, tbl[i].x_err);
            if (tbl[i].chk_alu) chk("tbl.alu", alu_o, tbl[i].x_alu);
        end

        // load with three ack-less WAIT cycles, ack on the fourth
        set_op(2'b11, 1, 0, 32'h0000_0100, 32'h0, 5'd7);
        stall_cnt = 0; req_cnt = 0;
        repeat (4) cycle();
        dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
        cycle();
        dmem_ack_i = 0;
        set_op(2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("ld.wb", wb_o, 2'b11);
        chk("ld.rdata", rdata_o, 32'hDEAD_BEEF);
        chk("ld.rd", rd_o, 7);
        chk("ld.alu", alu_o, 32'h100);
        chk("ld.stalls", stall_cnt, 4);
        chk("ld.reqs", req_cnt, 4);
        cycle();

        // store acknowledged in the first WAIT cycle
        set_op(2'b01, 0, 1, 32'h0000_0204, 32'h1234_5678, 5'd3);
        stall_cnt = 0; req_cnt = 0;
        cycle();
        chk("st.we", dmem_we_o, 1);
        chk("st.wdata", dmem_wdata_o, 32'h1234_5678);
        chk("st.addr", dmem_addr_o, 32'h204);
        dmem_ack_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        cycle();
        dmem_ack_i = 0;
        set_op(2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("st.stalls", stall_cnt, 1);
        chk("st.rdata", rdata_o, 0);
        chk("st.wb", wb_o, 2'b01);
        chk("st.rd", rd_o, 3);
        cycle();

        // timeout with no ack, then a prompt load
        set_op(2'b10, 1, 0, 32'h0000_0300, 32'h0, 5'd4);
        stall_cnt = 0; req_cnt = 0;
        repeat (1 + TMO) cycle();
        set_op(2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("to.err", err_o, 1);
        chk("to.wb", wb_o, 0);
        chk("to.req", dmem_req_o, 0);
        chk("to.stalls", stall_cnt, TMO);
        chk("to.reqs", req_cnt, TMO);
        cycle();
        chk("to.err_clr", err_o, 0);
        set_op(2'b11, 1, 0, 32'h0000_0008, 32'h0, 5'd12);
        cycle();
        dmem_ack_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
        cycle();
        dmem_ack_i = 0;
        set_op(2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("to.next_rdata", rdata_o, 32'hCAFE_F00D);
        chk("to.next_wb", wb_o, 2'b11);
        cycle();

        // reset during WAIT, then a read+write access that must issue as a write
        set_op(2'b10, 1, 0, 32'h0000_0400, 32'h0, 5'd6);
        repeat (2) cycle();
        chk("rw.req_before", dmem_req_o, 1);
        do_reset();
        set_op(2'b10, 1, 1, 32'h0000_0500, 32'hA5A5_A5A5, 5'd8);
        cycle();
        chk("rw.req", dmem_req_o, 1);
        chk("rw.we", dmem_we_o, 1);
        dmem_ack_i = 1;
        cycle();
        dmem_ack_i = 0;
        set_op(2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("rw.rdata", rdata_o, 0);
        cycle();

        // randomized traffic; EX/MEM inputs held while the model says the pipeline is stalled
        last_stall = 0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                int k = $urandom_range(0, 9);
                logic [31:0] a = $urandom;
                if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                set_op(2'($urandom), k >= 4 && k != 7 && k != 8, k >= 7, a, $urandom, 5'($urandom));
            end
            dmem_ack_i = ($urandom_range(0, 2) == 0);
            dmem_rdata_i = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
